// File: rtl/tri_pkg.sv
// Shared types for the triangle command path: word indices, the record
// layout as seen by the rasterizer, and the staging state encoding.
package tri_pkg;

  localparam int TRI_WORDS  = 6;
  localparam int TRI_WORD_W = 32;

  // Word index within a triangle record (AXI byte address >> 2).
  typedef enum logic [2:0] {
    V1XY   = 3'd0,
    V2X_Z1 = 3'd1,
    V2ZY   = 3'd2,
    V3XY   = 3'd3,
    COL_Z3 = 3'd4,
    RAREA  = 3'd5
  } tri_word_e;

  // Packed record; word k sits at bits [k*32 +: 32], so the last word is the MSB member.
  typedef struct packed {
    logic [TRI_WORD_W-1:0] rarea;
    logic [TRI_WORD_W-1:0] col_z3;
    logic [TRI_WORD_W-1:0] v3xy;
    logic [TRI_WORD_W-1:0] v2zy;
    logic [TRI_WORD_W-1:0] v2x_z1;
    logic [TRI_WORD_W-1:0] v1xy;
  } tri_rec_t;

  // Staging state: collecting words, or holding a committed record the FIFO had no room for.
  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_PENDING = 1'b1
  } stage_state_e;

endpackage

// File: rtl/tri_cmd_fifo_if.sv
// Bus bundle between AXI register decode (master) and the triangle command
// FIFO (slave), plus the rasterizer-side record stream.
//
// Handshakes:
//  - Word side: a word transfers on a cycle where wr_en & wr_ready. wr_en is a
//    one-cycle strobe; a strobe while wr_ready=0 is dropped and flagged in
//    err_sticky.
//  - Record side: the head record transfers on a cycle where tri_valid &
//    tri_ready. tri_data is valid whenever tri_valid=1 and holds until popped.
interface tri_cmd_fifo_if #(
  parameter int DATA_W        = 32,
  parameter int WORDS_PER_TRI = 6,
  parameter int DEPTH         = 16
);
  import tri_pkg::*;

  localparam int IDX_W = $clog2(WORDS_PER_TRI);
  localparam int REC_W = DATA_W * WORDS_PER_TRI;
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic                wr_en;
  logic [IDX_W-1:0]    wr_idx;
  logic [DATA_W-1:0]   wr_data;
  logic                wr_ready;
  logic                clear;
  logic                tri_valid;
  logic                tri_ready;
  logic [REC_W-1:0]    tri_data;
  logic [LVL_W-1:0]    level;
  logic                full;
  logic                empty;
  logic                err_sticky;
  stage_state_e        dbg_state;

  modport master (
    output wr_en, wr_idx, wr_data, clear, tri_ready,
    input  wr_ready, tri_valid, tri_data, level, full, empty, err_sticky, dbg_state
  );

  modport slave (
    input  wr_en, wr_idx, wr_data, clear, tri_ready,
    output wr_ready, tri_valid, tri_data, level, full, empty, err_sticky, dbg_state
  );

endinterface

// File: rtl/tri_cmd_fifo_sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO. The head entry is presented
// combinationally from the storage array; level is registered and full/empty
// derive from it. Pointers wrap naturally because DEPTH is a power of two.
module sync_fifo_fwft #(
  parameter int WIDTH = 192,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       arstn,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             do_pop;
  logic             do_push;

  // A pop frees the slot in the same cycle, so a push into a full FIFO is
  // accepted when it coincides with a pop.
  always_comb begin
    do_pop  = pop & (level_q != '0) & ~clear;
    do_push = push & ((level_q != LVL_W'(DEPTH)) | do_pop) & ~clear;
  end

  // Storage array; reset to zero so the head reads zero out of reset.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Pointers and occupancy; clear returns everything to the empty state.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      level_q <= level_q + LVL_W'(1);
      else if (do_pop && !do_push) level_q <= level_q - LVL_W'(1);
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign level = level_q;
  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);

endmodule

// File: rtl/tri_cmd_fifo.sv
// Triangle command FIFO: gathers individually addressed AXI word writes into
// a staging record, commits complete records into a FWFT FIFO for the
// rasterizer, and stalls the AXI side while a committed record waits for room.
module tri_cmd_fifo
  import tri_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int WORDS_PER_TRI = 6,
  parameter int DEPTH         = 16,
  parameter int COMMIT_MODE   = 0
) (
  input  logic          axi_aclk,
  input  logic          axi_aresetn,
  tri_cmd_fifo_if.slave bus
);

  localparam int IDX_W = $clog2(WORDS_PER_TRI);
  localparam int REC_W = DATA_W * WORDS_PER_TRI;
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam logic [WORDS_PER_TRI-1:0] ALL_WORDS = '1;
  localparam logic [IDX_W-1:0]         LAST_IDX  = IDX_W'(WORDS_PER_TRI - 1);

  stage_state_e             state_q, state_d;
  logic [DATA_W-1:0]        stage_q [WORDS_PER_TRI];
  logic [WORDS_PER_TRI-1:0] mask_q, mask_d;
  logic                     err_q, err_d;

  logic                     wr_fire;
  logic                     idx_ok;
  logic                     word_wr;
  logic [WORDS_PER_TRI-1:0] wr_bit;
  logic [WORDS_PER_TRI-1:0] mask_set;
  logic                     commit;
  logic                     want_push;
  logic                     can_push;
  logic                     push;
  logic                     pop;
  logic [REC_W-1:0]         rec_next;

  logic [REC_W-1:0]         f_rdata;
  logic [LVL_W-1:0]         f_level;
  logic                     f_full;
  logic                     f_empty;

  // Decode the word write, decide commit/push, and compute next staging state.
  always_comb begin
    wr_fire  = bus.wr_en & ~bus.clear;
    idx_ok   = ({1'b0, bus.wr_idx} < (IDX_W + 1)'(WORDS_PER_TRI));
    word_wr  = wr_fire & (state_q == ST_COLLECT) & idx_ok;
    wr_bit   = word_wr ? (WORDS_PER_TRI'(1) << bus.wr_idx) : '0;
    mask_set = mask_q | wr_bit;

    if (COMMIT_MODE == 0) commit = word_wr & (mask_set == ALL_WORDS);
    else                  commit = word_wr & (bus.wr_idx == LAST_IDX);

    // The pushed record includes the word arriving this cycle.
    rec_next = '0;
    for (int k = 0; k < WORDS_PER_TRI; k++) begin
      rec_next[k*DATA_W +: DATA_W] =
        (word_wr && bus.wr_idx == IDX_W'(k)) ? bus.wr_data : stage_q[k];
    end

    pop       = bus.tri_ready & ~f_empty & ~bus.clear;
    can_push  = ~f_full | pop;
    want_push = commit | (state_q == ST_PENDING);
    push      = want_push & can_push & ~bus.clear;

    state_d = state_q;
    mask_d  = mask_q;
    err_d   = err_q;

    if (bus.clear) begin
      state_d = ST_COLLECT;
      mask_d  = '0;
      err_d   = 1'b0;
    end else begin
      if (want_push && !can_push) state_d = ST_PENDING;
      else if (push)              state_d = ST_COLLECT;

      if (commit) mask_d = '0;
      else        mask_d = mask_set;

      if (wr_fire && (state_q == ST_PENDING || !idx_ok))
        err_d = 1'b1;
      else if (commit && COMMIT_MODE != 0 && mask_set != ALL_WORDS)
        err_d = 1'b1;
    end
  end

  // Staging state, written-word mask and sticky error flag.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q <= ST_COLLECT;
      mask_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
    end
  end

  // Staging words; last write wins and words survive commit and clear.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      for (int k = 0; k < WORDS_PER_TRI; k++) stage_q[k] <= '0;
    end else begin
      for (int k = 0; k < WORDS_PER_TRI; k++) begin
        if (word_wr && bus.wr_idx == IDX_W'(k)) stage_q[k] <= bus.wr_data;
      end
    end
  end

  sync_fifo_fwft #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (axi_aclk),
    .arstn (axi_aresetn),
    .clear (bus.clear),
    .push  (push),
    .wdata (rec_next),
    .pop   (pop),
    .rdata (f_rdata),
    .level (f_level),
    .full  (f_full),
    .empty (f_empty)
  );

  assign bus.wr_ready   = (state_q == ST_COLLECT);
  assign bus.tri_valid  = ~f_empty;
  assign bus.tri_data   = f_rdata;
  assign bus.level      = f_level;
  assign bus.full       = f_full;
  assign bus.empty      = f_empty;
  assign bus.err_sticky = err_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_tri_cmd_fifo.sv
// Bench for tri_cmd_fifo: two instances (commit mode 0 with DEPTH 4, commit
// mode 1 with DEPTH 16) driven from one directed+random sequence and compared
// every cycle against a queue-level behavioural model.
module tb_tri_cmd_fifo;
  import tri_pkg::*;

  localparam int DW = 32;
  localparam int NW = 6;
  localparam int IW = 3;
  localparam int RW = DW * NW;
  localparam int D0 = 4;
  localparam int D1 = 16;

  logic axi_aclk    = 1'b0;
  logic axi_aresetn = 1'b0;
  int   n_assert    = 0;
  int   n_fail      = 0;

  // clock
  always #5 axi_aclk = ~axi_aclk;

  tri_cmd_fifo_if #(.DATA_W(DW), .WORDS_PER_TRI(NW), .DEPTH(D0)) if0 ();
  tri_cmd_fifo_if #(.DATA_W(DW), .WORDS_PER_TRI(NW), .DEPTH(D1)) if1 ();

  tri_cmd_fifo #(.DATA_W(DW), .WORDS_PER_TRI(NW), .DEPTH(D0), .COMMIT_MODE(0)) u_dut0 (
    .axi_aclk    (axi_aclk),
    .axi_aresetn (axi_aresetn),
    .bus         (if0.slave)
  );

  tri_cmd_fifo #(.DATA_W(DW), .WORDS_PER_TRI(NW), .DEPTH(D1), .COMMIT_MODE(1)) u_dut1 (
    .axi_aclk    (axi_aclk),
    .axi_aresetn (axi_aresetn),
    .bus         (if1.slave)
  );

  // stimulus drive points, index = instance
  logic          in_we   [2];
  logic [IW-1:0] in_idx  [2];
  logic [DW-1:0] in_data [2];
  logic          in_clr  [2];
  logic          in_rdy  [2];

  assign if0.wr_en     = in_we[0];
  assign if0.wr_idx    = in_idx[0];
  assign if0.wr_data   = in_data[0];
  assign if0.clear     = in_clr[0];
  assign if0.tri_ready = in_rdy[0];
  assign if1.wr_en     = in_we[1];
  assign if1.wr_idx    = in_idx[1];
  assign if1.wr_data   = in_data[1];
  assign if1.clear     = in_clr[1];
  assign if1.tri_ready = in_rdy[1];

  // observed outputs
  logic          o_ready [2];
  logic          o_valid [2];
  logic [RW-1:0] o_data  [2];
  logic [31:0]   o_level [2];
  logic          o_full  [2];
  logic          o_empty [2];
  logic          o_err   [2];
  logic          o_pend  [2];

  assign o_ready[0] = if0.wr_ready;
  assign o_valid[0] = if0.tri_valid;
  assign o_data[0]  = if0.tri_data;
  assign o_level[0] = 32'(if0.level);
  assign o_full[0]  = if0.full;
  assign o_empty[0] = if0.empty;
  assign o_err[0]   = if0.err_sticky;
  assign o_pend[0]  = (if0.dbg_state == ST_PENDING);
  assign o_ready[1] = if1.wr_ready;
  assign o_valid[1] = if1.tri_valid;
  assign o_data[1]  = if1.tri_data;
  assign o_level[1] = 32'(if1.level);
  assign o_full[1]  = if1.full;
  assign o_empty[1] = if1.empty;
  assign o_err[1]   = if1.err_sticky;
  assign o_pend[1]  = (if1.dbg_state == ST_PENDING);

  // reference model: staged words + written set, a pending flag, and the
  // stored records as an ordered list (element 0 = oldest)
  logic [DW-1:0] m_words [2][NW];
  logic [NW-1:0] m_mask  [2];
  bit            m_pend  [2];
  bit            m_err   [2];
  logic [RW-1:0] m_list  [2][32];
  int            m_cnt   [2];

  function automatic int depth_of(int d);
    return (d == 0) ? D0 : D1;
  endfunction

  function automatic int mode_of(int d);
    return d;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_mask[d] = '0;
      m_pend[d] = 1'b0;
      m_err[d]  = 1'b0;
      m_cnt[d]  = 0;
      for (int k = 0; k < NW; k++) m_words[d][k] = '0;
    end
  endtask

  task automatic model_edge(int d);
    logic [RW-1:0] rec;
    bit commit;
    bit pop;
    int idx;
    commit = 1'b0;
    idx    = int'(in_idx[d]);
    if (in_clr[d]) begin
      m_mask[d] = '0;
      m_pend[d] = 1'b0;
      m_cnt[d]  = 0;
      m_err[d]  = 1'b0;
      return;
    end
    pop = (m_cnt[d] > 0) && in_rdy[d];
    if (in_we[d]) begin
      if (m_pend[d] || idx >= NW) begin
        m_err[d] = 1'b1;
      end else begin
        m_words[d][idx] = in_data[d];
        m_mask[d][idx]  = 1'b1;
        if (mode_of(d) == 0) begin
          commit = (m_mask[d] == '1);
        end else if (idx == NW - 1) begin
          commit = 1'b1;
          if (m_mask[d] != '1) m_err[d] = 1'b1;
        end
      end
    end
    for (int k = 0; k < NW; k++) rec[k*DW +: DW] = m_words[d][k];
    if (pop) begin
      for (int i = 0; i < m_cnt[d] - 1; i++) m_list[d][i] = m_list[d][i+1];
      m_cnt[d]--;
    end
    if (commit || m_pend[d]) begin
      if (m_cnt[d] < depth_of(d)) begin
        m_list[d][m_cnt[d]] = rec;
        m_cnt[d]++;
        m_pend[d] = 1'b0;
      end else begin
        m_pend[d] = 1'b1;
      end
    end
    if (commit) m_mask[d] = '0;
  endtask

  task automatic chk(string tag, logic [RW-1:0] got, logic [RW-1:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_dut(int d, string tag);
    string p;
    p = $sformatf("%s_d%0d", tag, d);
    chk({p, "_wr_ready"}, RW'(o_ready[d]), RW'(!m_pend[d]));
    chk({p, "_pending"},  RW'(o_pend[d]),  RW'(m_pend[d]));
    chk({p, "_valid"},    RW'(o_valid[d]), RW'(m_cnt[d] > 0));
    chk({p, "_level"},    RW'(o_level[d]), RW'(m_cnt[d]));
    chk({p, "_full"},     RW'(o_full[d]),  RW'(m_cnt[d] == depth_of(d)));
    chk({p, "_empty"},    RW'(o_empty[d]), RW'(m_cnt[d] == 0));
    chk({p, "_err"},      RW'(o_err[d]),   RW'(m_err[d]));
    if (m_cnt[d] > 0) chk({p, "_data"}, o_data[d], m_list[d][0]);
  endtask

  task automatic check_reset_values(string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_d%0d_valid", tag, d), RW'(o_valid[d]), '0);
      chk($sformatf("%s_d%0d_data", tag, d),  o_data[d], '0);
      chk($sformatf("%s_d%0d_level", tag, d), RW'(o_level[d]), '0);
      chk($sformatf("%s_d%0d_full", tag, d),  RW'(o_full[d]), '0);
      chk($sformatf("%s_d%0d_empty", tag, d), RW'(o_empty[d]), RW'(1));
      chk($sformatf("%s_d%0d_err", tag, d),   RW'(o_err[d]), '0);
      chk($sformatf("%s_d%0d_ready", tag, d), RW'(o_ready[d]), RW'(1));
    end
  endtask

  // driver tasks: inputs change at the falling edge, DUT samples at the rising edge
  task automatic step(string tag);
    model_edge(0);
    model_edge(1);
    @(posedge axi_aclk);
    @(negedge axi_aclk);
    check_dut(0, tag);
    check_dut(1, tag);
  endtask

  task automatic idle_inputs();
    for (int d = 0; d < 2; d++) begin
      in_we[d]   = 1'b0;
      in_idx[d]  = '0;
      in_data[d] = '0;
      in_clr[d]  = 1'b0;
      in_rdy[d]  = 1'b0;
    end
  endtask

  task automatic wr(int d, int idx, logic [DW-1:0] data, string tag);
    in_we[d]   = 1'b1;
    in_idx[d]  = IW'(idx);
    in_data[d] = data;
    step(tag);
    in_we[d]   = 1'b0;
  endtask

  task automatic wr_rec(int d, int n, string tag);
    for (int k = 0; k < NW; k++) wr(d, k, DW'((n << 8) + k), tag);
  endtask

  task automatic pop1(int d, string tag);
    in_rdy[d] = 1'b1;
    step(tag);
    in_rdy[d] = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] t1_words [NW];
    tri_rec_t      rec;

    idle_inputs();
    model_reset();
    axi_aresetn = 1'b0;
    @(negedge axi_aclk);
    check_reset_values("reset");
    axi_aresetn = 1'b1;

    // 1: mode 0, in-order record, FWFT latency and word placement
    t1_words = '{32'h00140028, 32'h008C0032, 32'h00320078,
                 32'h00780028, 32'h00E00032, 32'h00028F5C};
    for (int k = 0; k < NW - 1; k++) wr(0, k, t1_words[k], "t1");
    chk("t1_no_early_valid", RW'(o_valid[0]), '0);
    wr(0, int'(RAREA), t1_words[NW-1], "t1");
    rec = tri_rec_t'(o_data[0]);
    chk("t1_valid", RW'(o_valid[0]), RW'(1));
    chk("t1_word5", RW'(rec.rarea), RW'(32'h00028F5C));
    chk("t1_word0", RW'(rec.v1xy), RW'(32'h00140028));
    chk("t1_level", RW'(o_level[0]), RW'(1));
    pop1(0, "t1_pop");
    chk("t1_empty_after_pop", RW'(o_empty[0]), RW'(1));

    // 2: out-of-order indices with a rewrite before the last distinct word
    wr(0, 5, 32'h5555_0005, "t2");
    wr(0, 3, 32'h5555_0003, "t2");
    wr(0, 1, 32'h5555_0001, "t2");
    wr(0, 0, 32'h5555_0000, "t2");
    wr(0, 4, 32'h5555_0004, "t2");
    wr(0, 1, 32'hAAAA_0011, "t2");
    chk("t2_no_commit_yet", RW'(o_level[0]), '0);
    wr(0, 2, 32'h5555_0002, "t2");
    chk("t2_level", RW'(o_level[0]), RW'(1));
    chk("t2_word1_rewritten", RW'(o_data[0][1*DW +: DW]), RW'(32'hAAAA_0011));
    pop1(0, "t2_pop");

    // 3: fill DEPTH=4, fifth commit stalls, single pop releases it
    for (int n = 1; n <= 4; n++) wr_rec(0, n, "t3");
    chk("t3_full", RW'(o_full[0]), RW'(1));
    wr_rec(0, 5, "t3");
    chk("t3_stall_ready", RW'(o_ready[0]), '0);
    chk("t3_head_1", RW'(o_data[0][DW-1:0]), RW'(32'h100));
    pop1(0, "t3_pulse");
    chk("t3_level_after_pulse", RW'(o_level[0]), RW'(4));
    chk("t3_ready_after_pulse", RW'(o_ready[0]), RW'(1));
    for (int n = 2; n <= 5; n++) begin
      chk($sformatf("t3_order_%0d", n), RW'(o_data[0][DW-1:0]), RW'(n << 8));
      pop1(0, "t3_drain");
    end
    chk("t3_drained", RW'(o_empty[0]), RW'(1));

    // 4: full FIFO, commit and pop in the same cycle
    for (int n = 6; n <= 9; n++) wr_rec(0, n, "t4");
    for (int k = 0; k < NW - 1; k++) wr(0, k, DW'((10 << 8) + k), "t4");
    in_rdy[0] = 1'b1;
    wr(0, NW - 1, DW'((10 << 8) + NW - 1), "t4_same_cycle");
    in_rdy[0] = 1'b0;
    chk("t4_level", RW'(o_level[0]), RW'(4));
    chk("t4_ready", RW'(o_ready[0]), RW'(1));
    for (int n = 7; n <= 10; n++) begin
      chk($sformatf("t4_order_%0d", n), RW'(o_data[0][DW-1:0]), RW'(n << 8));
      pop1(0, "t4_drain");
    end

    // 5: mode 1, commit on last index with missing words, bad index
    wr(1, 0, 32'hC0DE_0000, "t5");
    wr(1, 5, 32'hC0DE_0005, "t5");
    chk("t5_valid", RW'(o_valid[1]), RW'(1));
    chk("t5_err", RW'(o_err[1]), RW'(1));
    chk("t5_word5", RW'(o_data[1][5*DW +: DW]), RW'(32'hC0DE_0005));
    wr(1, 7, 32'hDEAD_BEEF, "t5_bad_idx");
    chk("t5_err_stays", RW'(o_err[1]), RW'(1));
    chk("t5_level_unchanged", RW'(o_level[1]), RW'(1));
    pop1(1, "t5_pop");

    // 6a: asynchronous reset in the middle of a record
    for (int k = 0; k < 3; k++) wr(0, k, DW'(32'hBAD0 + k), "t6a");
    axi_aresetn = 1'b0;
    #2;
    model_reset();
    check_reset_values("t6a_async");
    @(posedge axi_aclk);
    @(negedge axi_aclk);
    axi_aresetn = 1'b1;
    wr_rec(0, 32'h60, "t6a");
    chk("t6a_one_record", RW'(o_level[0]), RW'(1));
    chk("t6a_head", RW'(o_data[0][DW-1:0]), RW'(32'h6000));
    pop1(0, "t6a_pop");
    chk("t6a_empty", RW'(o_empty[0]), RW'(1));

    // 6b: clear with two queued records, a partial record and a set error flag
    wr_rec(0, 32'h71, "t6b");
    wr_rec(0, 32'h72, "t6b");
    wr(0, 0, 32'h7300, "t6b");
    wr(0, 1, 32'h7301, "t6b");
    wr(0, 7, 32'h7307, "t6b");
    chk("t6b_err_before", RW'(o_err[0]), RW'(1));
    in_clr[0] = 1'b1;
    in_rdy[0] = 1'b1;
    wr(0, 2, 32'h7302, "t6b_clear");
    in_clr[0] = 1'b0;
    in_rdy[0] = 1'b0;
    chk("t6b_level", RW'(o_level[0]), '0);
    chk("t6b_err_cleared", RW'(o_err[0]), '0);
    wr_rec(0, 32'h80, "t6b");
    chk("t6b_one_record", RW'(o_level[0]), RW'(1));
    chk("t6b_head", RW'(o_data[0][DW-1:0]), RW'(32'h8000));
    pop1(0, "t6b_pop");
    chk("t6b_empty", RW'(o_empty[0]), RW'(1));

    // randomized traffic: slow consumer first (stalls), then a fast one
    for (int c = 0; c < 3000; c++) begin
      for (int d = 0; d < 2; d++) begin
        in_we[d]   = ($urandom_range(0, 2) != 0) && (!m_pend[d] || $urandom_range(0, 7) == 0);
        in_idx[d]  = ($urandom_range(0, 31) == 0) ? IW'($urandom_range(6, 7))
                                                  : IW'($urandom_range(0, 5));
        in_data[d] = $urandom;
        in_rdy[d]  = (c < 1500) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 1);
        in_clr[d]  = ($urandom_range(0, 299) == 0);
      end
      step("rnd");
    end
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
